wb_ram_initiator: RTL and testbench

//  Wishbone initiator (master) that drives the byte-enable RAM responder: fills a

---
 rtl/wb_ram_initiator.sv | 191 +++++++++++++++++++
 tb/tb_wb_ram_initiator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_initiator.sv
// rtl/wb_ram_initiator.sv - Wishbone fill/readback self-test initiator for the byte-enable RAM
// Optional feature macro: WBINIT_ERR_CAPTURE_EN (adds first-miscompare address/data capture)
module wb_ram_initiator #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst_n,
  input  logic            i_start,
  input  logic [31:0]     i_seed,
  input  logic [3:0]      i_sel,
  output logic [aw-1:0]   o_wb_adr,
  output logic [31:0]     o_wb_dat,
  output logic [3:0]      o_wb_sel,
  output logic            o_wb_we,
  output logic            o_wb_cyc,
  input  logic [31:0]     i_wb_rdt,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
`ifdef WBINIT_ERR_CAPTURE_EN
  output logic [aw-1:0]   o_err_adr,
  output logic [31:0]     o_err_rdt,
`endif
  output logic [aw-2:0]   o_err_cnt
);

  localparam int N  = depth / 4;
  localparam int WW = aw - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   word;
  logic [WW-1:0]   word_nxt;
  logic [31:0]     seed_q;
  logic [3:0]      sel_q;
  logic            rd_vld;
  logic [31:0]     exp_q;
  logic [31:0]     mask;
  logic            miss;
  logic            last_word;
  logic            start_ok;

  assign last_word = (word == WW'(N - 1));
  assign start_ok  = (state == S_IDLE) && i_start;
  assign mask      = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
  assign miss      = rd_vld && (((i_wb_rdt ^ exp_q) & mask) != 32'h0);

  // State and word-index register; async reset drops the bus immediately
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state <= S_IDLE;
      word  <= '0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
    end
  end

  // Next-state sequencing and bus outputs decoded from the current state
  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    o_wb_cyc  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_adr  = '0;
    o_wb_dat  = 32'h0;
    o_wb_sel  = 4'h0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_WRITE;
          word_nxt  = '0;
        end
      end
      S_WRITE: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_adr = {word, 2'b00};
        o_wb_dat = seed_q ^ 32'(word);
        o_wb_sel = sel_q;
        o_busy   = 1'b1;
        if (last_word) begin
          state_nxt = S_READ;
          word_nxt  = '0;
        end else begin
          word_nxt = word + 1'b1;
        end
      end
      S_READ: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = {word, 2'b00};
        o_wb_sel = 4'hF;
        o_busy   = 1'b1;
        if (last_word) begin
          state_nxt = S_DRAIN;
          word_nxt  = '0;
        end else begin
          word_nxt = word + 1'b1;
        end
      end
      S_DRAIN: begin
        o_busy    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run configuration latched at start so inputs may change mid-run
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      seed_q <= 32'h0;
      sel_q  <= 4'h0;
    end else if (start_ok) begin
      seed_q <= i_seed;
      sel_q  <= i_sel;
    end
  end

  // Expected data travels one cycle behind the read address to meet the RAM's read latency
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rd_vld <= 1'b0;
      exp_q  <= 32'h0;
    end else begin
      rd_vld <= (state == S_READ);
      exp_q  <= seed_q ^ 32'(word);
    end
  end

  // Miscompare counter and pass flag; pass folds in the final compare done in DRAIN
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_err_cnt <= '0;
      o_pass    <= 1'b0;
    end else if (start_ok) begin
      o_err_cnt <= '0;
      o_pass    <= 1'b0;
    end else begin
      if (miss) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
      if (state == S_DRAIN) begin
        o_pass <= (o_err_cnt == '0) && !miss;
      end
    end
  end

`ifdef WBINIT_ERR_CAPTURE_EN
  logic [aw-1:0] rd_adr;

  // Byte address of the word whose data is being compared this cycle
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rd_adr <= '0;
    end else begin
      rd_adr <= {word, 2'b00};
    end
  end

  // First miscompare of the run is captured; later ones leave it untouched
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_err_adr <= '0;
      o_err_rdt <= 32'h0;
    end else if (start_ok) begin
      o_err_adr <= '0;
      o_err_rdt <= 32'h0;
    end else if (miss && (o_err_cnt == '0)) begin
      o_err_adr <= rd_adr;
      o_err_rdt <= i_wb_rdt;
    end
  end
`endif

endmodule

// File: tb/tb_wb_ram_initiator.sv
// tb/tb_wb_ram_initiator.sv - randomized self-checking bench for wb_ram_initiator with a byte-enable RAM model
module tb_wb_ram_initiator;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int N     = DEPTH / 4;
  localparam int DONE_CYC = 2 * N + 2;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [31:0]   i_seed;
  logic [3:0]    i_sel;
  logic [AW-1:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_cyc;
  logic [31:0]   i_wb_rdt;
  logic          o_busy;
  logic          o_done;
  logic          o_pass;
  logic [AW-2:0] o_err_cnt;
`ifdef WBINIT_ERR_CAPTURE_EN
  logic [AW-1:0] o_err_adr;
  logic [31:0]   o_err_rdt;
`endif

  int checks   = 0;
  int failures = 0;

  wb_ram_initiator #(.depth(DEPTH)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_start    (i_start),
    .i_seed     (i_seed),
    .i_sel      (i_sel),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass     (o_pass),
`ifdef WBINIT_ERR_CAPTURE_EN
    .o_err_adr  (o_err_adr),
    .o_err_rdt  (o_err_rdt),
`endif
    .o_err_cnt  (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM responder model: byte-enable writes, registered read, stuck-at-1 faults on read
  logic [31:0] mem   [0:N-1];
  logic [31:0] stuck [0:N-1];
  logic        preload_en;
  logic [31:0] preload_val;

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < N; i++) mem[i] <= preload_val;
    end else if (o_wb_cyc && o_wb_we) begin
      for (int b = 0; b < 4; b++)
        if (o_wb_sel[b]) mem[o_wb_adr[AW-1:2]][8*b +: 8] <= o_wb_dat[8*b +: 8];
    end
    if (o_wb_cyc && !o_wb_we) i_wb_rdt <= mem[o_wb_adr[AW-1:2]] | stuck[o_wb_adr[AW-1:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: what each word should hold after the fill, and what the readback reveals
  task automatic model(input logic [31:0] seed, input logic [3:0] sel, input logic [31:0] pre,
                       output int e_cnt, output logic [AW-1:0] e_adr, output logic [31:0] e_rdt);
    logic [31:0] m, wv, stored, rd;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = sel[b] ? 8'hFF : 8'h00;
    e_cnt = 0;
    e_adr = '0;
    e_rdt = 32'h0;
    for (int w = 0; w < N; w++) begin
      wv     = seed ^ w;
      stored = (pre & ~m) | (wv & m);
      rd     = stored | stuck[w];
      if (((rd ^ wv) & m) != 32'h0) begin
        if (e_cnt == 0) begin
          e_adr = AW'(w * 4);
          e_rdt = rd;
        end
        e_cnt++;
      end
    end
  endtask

  task automatic clear_stuck();
    for (int i = 0; i < N; i++) stuck[i] = 32'h0;
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] seed, input logic [3:0] sel,
                         input logic [31:0] pre);
    int            dc;
    int            e_cnt;
    logic [AW-1:0] e_adr;
    logic [31:0]   e_rdt;
    preload(pre);
    model(seed, sel, pre, e_cnt, e_adr, e_rdt);
    i_seed  = seed;
    i_sel   = sel;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    i_seed = $urandom;
    i_sel  = 4'($urandom);
    dc = -1;
    for (int c = 1; c <= 300 && dc < 0; c++) begin
      @(negedge clk);
      if (o_done) dc = c;
    end
    check({tag, "_done_cyc"}, 64'(dc), 64'(DONE_CYC));
    check({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(e_cnt));
    check({tag, "_pass"}, 64'(o_pass), 64'(e_cnt == 0));
`ifdef WBINIT_ERR_CAPTURE_EN
    check({tag, "_err_adr"}, 64'(o_err_adr), 64'(e_adr));
    check({tag, "_err_rdt"}, 64'(o_err_rdt), 64'(e_rdt));
`endif
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(o_busy), 64'(0));
    check({tag, "_hold_cnt"}, 64'(o_err_cnt), 64'(e_cnt));
  endtask

  initial begin
    int            dq[$];
    int            dn;
    logic [31:0]   s;
    logic [3:0]    sl;
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_seed      = 32'h0;
    i_sel       = 4'h0;
    preload_en  = 1'b0;
    preload_val = 32'h0;
    clear_stuck();
    #3;
    check("rst_cyc",  64'(o_wb_cyc), 64'(0));
    check("rst_we",   64'(o_wb_we), 64'(0));
    check("rst_adr",  64'(o_wb_adr), 64'(0));
    check("rst_dat",  64'(o_wb_dat), 64'(0));
    check("rst_sel",  64'(o_wb_sel), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_pass", 64'(o_pass), 64'(0));
    check("rst_cnt",  64'(o_err_cnt), 64'(0));
`ifdef WBINIT_ERR_CAPTURE_EN
    check("rst_eadr", 64'(o_err_adr), 64'(0));
    check("rst_erdt", 64'(o_err_rdt), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_one("basic", 32'hA5A5_0000, 4'hF, 32'h0);
    check("basic_word5", 64'(mem[5]), 64'h0000_0000_A5A5_0005);
    check("basic_pass_c", 64'(o_pass), 64'(1));

    stuck[10] = 32'h1;
    run_one("stuck", 32'h0, 4'hF, 32'h0);
    check("stuck_cnt_c", 64'(o_err_cnt), 64'(1));
`ifdef WBINIT_ERR_CAPTURE_EN
    check("stuck_adr_c", 64'(o_err_adr), 64'h28);
    check("stuck_rdt_c", 64'(o_err_rdt), 64'h0000_000B);
`endif
    clear_stuck();

    run_one("lanes", 32'h1234_0000, 4'h3, 32'hFFFF_FFFF);
    check("lanes_word3", 64'(mem[3]), 64'h0000_0000_FFFF_0003);
    check("lanes_pass_c", 64'(o_pass), 64'(1));

    run_one("sel0", 32'hDEAD_BEEF, 4'h0, 32'h0);
    check("sel0_word7", 64'(mem[7]), 64'h0);

    for (int r = 0; r < 6; r++) begin
      clear_stuck();
      for (int k = $urandom_range(0, 3); k > 0; k--)
        stuck[$urandom_range(0, N - 1)] |= 32'h1 << $urandom_range(0, 31);
      s  = $urandom;
      sl = 4'($urandom_range(0, 15));
      run_one($sformatf("rnd%0d", r), s, sl, $urandom);
    end
    clear_stuck();

    // start held high: one done per run, re-sampled only in IDLE
    preload(32'h0);
    i_seed  = 32'h0BAD_0000;
    i_sel   = 4'hF;
    i_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (o_done) begin
        dq.push_back(c);
        if (dq.size() == 2) i_start = 1'b0;
      end
      if (c == DONE_CYC + 1) check("hold_idle_busy", 64'(o_busy), 64'(0));
      if (c == DONE_CYC + 2) check("hold_restart_busy", 64'(o_busy), 64'(1));
    end
    i_start = 1'b0;
    check("hold_done_n", 64'(dq.size()), 64'(2));
    if (dq.size() == 2) begin
      check("hold_done0", 64'(dq[0]), 64'(DONE_CYC));
      check("hold_done1", 64'(dq[1]), 64'(2 * DONE_CYC + 1));
    end
    check("hold_pass", 64'(o_pass), 64'(1));

    // reset during READ
    preload(32'h0);
    i_seed  = 32'h5555_0000;
    i_sel   = 4'hF;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (80) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc",  64'(o_wb_cyc), 64'(0));
    check("mid_rst_we",   64'(o_wb_we), 64'(0));
    check("mid_rst_busy", 64'(o_busy), 64'(0));
    check("mid_rst_done", 64'(o_done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    check("mid_rst_nodone", 64'(dn), 64'(0));
    run_one("post_rst", 32'h7777_0000, 4'hF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
